// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving the datapath control strobes.
// Define CU_HALT_EN to build the HALT state for opcode 11011.
module control_unit #(
  parameter int OPW  = 5,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     IR,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic            ADD,
  output logic            SUB,
  output logic            AND,
  output logic            OR,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            Run,
  output logic [CNTW-1:0] instr_count
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
`ifdef CU_HALT_EN
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);
`endif

  typedef enum logic [3:0] {
    S_RST,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6
`ifdef CU_HALT_EN
    , S_HALT
`endif
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic mdr_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic inc_pc;
    logic read;
    logic alu_add;
    logic alu_sub;
    logic alu_and;
    logic alu_or;
    logic gra;
    logic grc;
    logic rin;
    logic rout;
    logic run;
  } ctrl_t;

  state_t          state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [CNTW-1:0] instr_count_q, instr_count_d;

  logic [OPW-1:0]  opcode;
  logic            is_alu_op;
  logic            in_t4_alu;
  logic            retire;
  logic            unused_ir_bits;

  assign opcode         = IR[31 -: OPW];
  assign unused_ir_bits = ^IR[31-OPW:0];
  assign is_alu_op      = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                          (opcode == OP_AND) || (opcode == OP_OR);

  // IR is only loaded at the end of T3, so the T4 operand fetch must follow
  // the live opcode rather than a strobe registered while still in T3.
  assign in_t4_alu = (state_q == S_T4) && is_alu_op;
  assign retire    = (state_q == S_T6) || ((state_q == S_T4) && !is_alu_op);

  always_comb begin
    // NOTE: default first so every path assigns the variable and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = mem_ready ? S_T3 : S_T2;
      S_T3:  state_d = S_T4;
      S_T4: begin
        if (is_alu_op) begin
          state_d = S_T5;
`ifdef CU_HALT_EN
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
`endif
        end else begin
          state_d = S_T0;
        end
      end
      S_T5:  state_d = S_T6;
      S_T6:  state_d = S_T0;
`ifdef CU_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_RST;
    endcase
  end

  // Strobes are decoded from the state being entered so they appear right after the edge.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.z_in   = 1'b1;
        ctrl_d.run    = 1'b1;
      end
      S_T1: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.pc_in    = 1'b1;
        ctrl_d.run      = 1'b1;
      end
      S_T2: begin
        ctrl_d.read   = 1'b1;
        ctrl_d.mdr_in = 1'b1;
        ctrl_d.run    = 1'b1;
      end
      S_T3: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
        ctrl_d.run     = 1'b1;
      end
      S_T4: ctrl_d.run = 1'b1;
      S_T5: begin
        ctrl_d.grc     = 1'b1;
        ctrl_d.rout    = 1'b1;
        ctrl_d.z_in    = 1'b1;
        ctrl_d.run     = 1'b1;
        ctrl_d.alu_add = (opcode == OP_ADD);
        ctrl_d.alu_sub = (opcode == OP_SUB);
        ctrl_d.alu_and = (opcode == OP_AND);
        ctrl_d.alu_or  = (opcode == OP_OR);
      end
      S_T6: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.gra      = 1'b1;
        ctrl_d.rin      = 1'b1;
        ctrl_d.run      = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  always_comb begin
    instr_count_d = instr_count_q + CNTW'(retire);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RST;
      ctrl_q        <= '0;
      instr_count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign PCout       = ctrl_q.pc_out;
  assign Zlowout     = ctrl_q.zlow_out;
  assign MDRout      = ctrl_q.mdr_out;
  assign MARin       = ctrl_q.mar_in;
  assign Zin         = ctrl_q.z_in;
  assign PCin        = ctrl_q.pc_in;
  assign MDRin       = ctrl_q.mdr_in;
  assign IRin        = ctrl_q.ir_in;
  assign Yin         = in_t4_alu;
  assign IncPC       = ctrl_q.inc_pc;
  assign Read        = ctrl_q.read;
  assign ADD         = ctrl_q.alu_add;
  assign SUB         = ctrl_q.alu_sub;
  assign AND         = ctrl_q.alu_and;
  assign OR          = ctrl_q.alu_or;
  assign Gra         = ctrl_q.gra;
  assign Grb         = in_t4_alu;
  assign Grc         = ctrl_q.grc;
  assign Rin         = ctrl_q.rin;
  assign Rout        = ctrl_q.rout | in_t4_alu;
  assign Run         = ctrl_q.run;
  assign instr_count = instr_count_q;

endmodule
